module_control_multiciclo: RTL
==============================

// Module: module_control_multiciclo
// PURPOSE
//  Multicycle RV32I control unit: Moore FSM that sequences fetch/decode/execute over shared memory and ALU.
//  Drives alu_control_o in the team ALU encoding and consumes the ALU zero flag for branches.
//  Sits between the instruction register (instr_i) and the multicycle datapath muxes and write enables.
// PARAMETERS
//  SUPPORT_BNE  1  1: bne (funct3 001) decoded as a branch; 0: bne flagged illegal
// PORTS
//  clk_i          in   1   system clock, rising edge
//  rst_n_i        in   1   asynchronous active-low reset
//  instr_i        in   32  instruction register contents, stable from DECODE until next FETCH
//  zero_i         in   1   ALU zero flag
//  pc_write_o     out  1   PC register load enable
//  adr_src_o      out  1   memory address: 0=PC, 1=ALUOut
//  mem_write_o    out  1   data memory write enable
//  ir_write_o     out  1   instruction register and oldPC load enable
//  result_src_o   out  2   result mux: 00=ALUOut, 01=mem data reg, 10=ALU output direct
//  alu_src_a_o    out  2   ALU A: 00=PC, 01=oldPC, 10=rs1 reg
//  alu_src_b_o    out  2   ALU B: 00=rs2 reg, 01=imm, 10=const 4
//  imm_src_o      out  2   immediate format: 00=I, 01=S, 10=B, 11=J
//  reg_write_o    out  1   register file write enable
//  alu_control_o  out  3   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//  illegal_o      out  1   one-cycle pulse in DECODE on an unsupported encoding
// BEHAVIOUR
//  - Reset: state=FETCH asynchronously. While rst_n_i=0, pc_write/ir_write/reg_write/mem_write/illegal=0.
//    All other outputs take FETCH values. First FETCH is the first clk_i edge after release.
//  - Outputs are Moore, decoded from state. Exceptions: imm_src_o is decoded from opcode;
//    alu_control_o in EXECUTER/EXECUTEI decodes funct3/funct7; pc_write_o in BRANCH depends on zero_i.
//  - Unlisted outputs are 0; alu default is add.
//  - FETCH: adr_src=0, ir_write=1, A=00, B=10, add, result_src=10, pc_write=1 -> DECODE.
//  - DECODE: A=01, B=01, add (branch/jal target into ALUOut).
//    Next state: lw/sw->MEMADR, R(0110011)->EXECUTER, I-ALU(0010011)->EXECUTEI, beq/bne->BRANCH,
//    jal->JAL, else illegal_o=1 -> FETCH.
//  - MEMADR: A=10, B=01, add. Next: lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: adr_src=1, result_src=00 -> MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
//  - EXECUTER: A=10, B=00 -> ALUWB.
//  - EXECUTEI: A=10, B=01 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BRANCH: A=10, B=00, sub, result_src=00.
//    pc_write = beq ? zero_i : ~zero_i (bne) -> FETCH.
//  - JAL: A=01, B=10, add, result_src=00, pc_write=1 -> ALUWB (rd=oldPC+4).
//  - funct3 map: 000 add (sub if R and funct7=0100000), 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
//  - Legal R-type funct7: 0000000, or 0100000 with funct3=000 only.
//  - slli/srli need funct7=0000000; srai/sra/sltu/sltiu/011 are illegal. Illegality is checked in DECODE only.
//  - Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, branch 3, illegal 2.
//  - Reset mid-instruction: abort immediately and drop all write enables; no partial write may complete.
//  - imm_src_o by opcode: lw/I-ALU=00, sw=01, branch=10, jal=11, others 00.
// TESTING
//  - Reset held low 3 cycles, then released.
//    -> All enables 0 while low. After the first edge: FETCH outputs, ir_write=1, pc_write=1, alu=000.
//  - lw x5,8(x1) (0x0080A283).
//    -> States FETCH,DECODE,MEMADR,MEMREAD,MEMWB. reg_write=1 only in cycle 5, result_src=01.
//  - sub x3,x1,x2 (0x402081B3), then sra (0x4020D1B3).
//    -> sub: alu=001 in EXECUTER, then ALUWB. sra: illegal_o=1 in DECODE, next state FETCH.
//  - beq x1,x2,+16 (0x00208863) with zero_i=1, then zero_i=0.
//    -> pc_write=1 in BRANCH only when zero_i=1. 3 cycles each.
//  - bne (0x00209863) with SUPPORT_BNE=0. -> illegal_o pulse, no pc_write after FETCH.
//  - jal x1,+8 (0x008000EF), rst_n_i dropped during ALUWB.
//    -> JAL: pc_write=1, A=01, B=10. reg_write never asserted. FETCH after release.

Source files
------------

// File: rtl/module_control_multiciclo.sv
// ---------------------------------------------------------------------------
// module_control_multiciclo
// Multicycle RV32I control unit. A Moore FSM steps each instruction through
// fetch, decode and execute phases. It drives the datapath muxes, the write
// enables and the ALU operation, and it uses the ALU zero flag for branches.
//
// Parameters
//   SUPPORT_BNE   1: bne is decoded as a branch; 0: bne is flagged illegal
// Ports
//   clk_i          in   clock, rising edge
//   rst_n_i        in   asynchronous active-low reset
//   instr_i        in   [31:0] instruction register contents
//   zero_i         in   ALU zero flag
//   pc_write_o     out  PC load enable
//   adr_src_o      out  memory address select (0 PC, 1 ALUOut)
//   mem_write_o    out  data memory write enable
//   ir_write_o     out  IR / oldPC load enable
//   result_src_o   out  [1:0] result mux (00 ALUOut, 01 data reg, 10 ALU)
//   alu_src_a_o    out  [1:0] ALU A select (00 PC, 01 oldPC, 10 rs1)
//   alu_src_b_o    out  [1:0] ALU B select (00 rs2, 01 imm, 10 const 4)
//   imm_src_o      out  [1:0] immediate format (00 I, 01 S, 10 B, 11 J)
//   reg_write_o    out  register file write enable
//   alu_control_o  out  [2:0] ALU operation
//   illegal_o      out  pulse in DECODE on an unsupported encoding
// ---------------------------------------------------------------------------
module module_control_multiciclo #(
    parameter int SUPPORT_BNE = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    output logic        pc_write_o,
    output logic        adr_src_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  imm_src_o,
    output logic        reg_write_o,
    output logic [2:0]  alu_control_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic        pc_write_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        illegal_s;
    logic        r_legal_s;
    logic        i_legal_s;
    logic        br_legal_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        unused_bits_s;

    assign opcode_s      = instr_i[6:0];
    assign funct3_s      = instr_i[14:12];
    assign funct7_s      = instr_i[31:25];
    assign unused_bits_s = ^{instr_i[24:15], instr_i[11:7]};

    // funct3 to ALU operation; 011 (sltu) never reaches execute
    function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_from_funct3 = ALU_ADD;
            3'b001:  alu_from_funct3 = ALU_SLL;
            3'b010:  alu_from_funct3 = ALU_SLT;
            3'b100:  alu_from_funct3 = ALU_XOR;
            3'b101:  alu_from_funct3 = ALU_SRL;
            3'b110:  alu_from_funct3 = ALU_OR;
            3'b111:  alu_from_funct3 = ALU_AND;
            default: alu_from_funct3 = ALU_ADD;
        endcase
    endfunction

    // Legality: R allows funct7=0 or sub only; I shifts need funct7=0; no sra/sltu
    assign r_legal_s  = (funct3_s != 3'b011) &&
                        ((funct7_s == 7'b0000000) ||
                         ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)));
    assign i_legal_s  = (funct3_s != 3'b011) &&
                        (((funct3_s != 3'b001) && (funct3_s != 3'b101)) ||
                         (funct7_s == 7'b0000000));
    assign br_legal_s = (funct3_s == 3'b000) ||
                        ((funct3_s == 3'b001) && (SUPPORT_BNE != 0));

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_s        = S_FETCH;
        pc_write_s    = 1'b0;
        adr_src_o     = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        result_src_o  = 2'b00;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        reg_write_s   = 1'b0;
        alu_control_o = ALU_ADD;
        illegal_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                pc_write_s   = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                next_s       = S_DECODE;
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUOut as branch/jal target
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_s)
                    // only word-sized memory accesses are supported
                    OP_LOAD, OP_STORE: begin
                        if (funct3_s == 3'b010) next_s = S_MEMADR;
                        else                    illegal_s = 1'b1;
                    end
                    OP_R: begin
                        if (r_legal_s) next_s = S_EXECUTER;
                        else           illegal_s = 1'b1;
                    end
                    OP_I: begin
                        if (i_legal_s) next_s = S_EXECUTEI;
                        else           illegal_s = 1'b1;
                    end
                    OP_BRANCH: begin
                        if (br_legal_s) next_s = S_BRANCH;
                        else            illegal_s = 1'b1;
                    end
                    OP_JAL:  next_s    = S_JAL;
                    default: illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (opcode_s == OP_LOAD) next_s = S_MEMREAD;
                else                     next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_o = 1'b1;
                next_s    = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_o = 2'b10;
                if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) alu_control_o = ALU_SUB;
                else alu_control_o = alu_from_funct3(funct3_s);
                next_s = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b01;
                alu_control_o = alu_from_funct3(funct3_s);
                next_s        = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = ALU_SUB;
                // funct3[0] set means bne
                pc_write_s    = funct3_s[0] ? ~zero_i : zero_i;
            end
            S_JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_s  = 1'b1;
                next_s      = S_ALUWB;
            end
            default: next_s = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (opcode_s)
            OP_STORE:  imm_src_o = 2'b01;
            OP_BRANCH: imm_src_o = 2'b10;
            OP_JAL:    imm_src_o = 2'b11;
            default:   imm_src_o = 2'b00;
        endcase
    end

    // Enables are forced low while reset is asserted, even though FETCH raises them
    assign pc_write_o  = pc_write_s  & rst_n_i;
    assign mem_write_o = mem_write_s & rst_n_i;
    assign ir_write_o  = ir_write_s  & rst_n_i;
    assign reg_write_o = reg_write_s & rst_n_i;
    assign illegal_o   = illegal_s   & rst_n_i;

endmodule
